// File: rtl/pc_stack_ctr.sv
// pc_stack_ctr: program counter with a hardware return-address stack.
//
// Each rising edge applies at most one command. The priority order is
// R > ret > call > load > inc > hold.
//
// Ports:
//   clk   - clock; all state updates on the rising edge
//   R     - synchronous active-high reset
//   inc   - Q <= Q+1
//   load  - Q <= D
//   call  - push Q+1, then Q <= D. When the stack is full: fall through and set ovf.
//   ret   - pop into Q. When the stack is empty: fall through and set unf.
//   D     - jump/call target
//   Q     - current PC
//   top   - top-of-stack entry, zero when empty
//   sp    - number of valid stack entries, 0..DEPTH
//   full  - sp == DEPTH
//   empty - sp == 0
//   ovf   - sticky: a call was attempted while full
//   unf   - sticky: a ret was attempted while empty
module pc_stack_ctr #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4,
  parameter int SP_W   = 3
) (
  input  logic              clk,
  input  logic              R,
  input  logic              inc,
  input  logic              load,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] D,
  output logic [ADDR_W-1:0] Q,
  output logic [ADDR_W-1:0] top,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  logic [ADDR_W-1:0] r_stack [DEPTH];
  logic [ADDR_W-1:0] r_q;
  logic [SP_W-1:0]   r_sp;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_q_d;
  logic [ADDR_W-1:0] w_q_inc;
  logic [ADDR_W-1:0] w_top;
  logic [SP_W-1:0]   w_sp_d;
  logic              w_ovf_d;
  logic              w_unf_d;
  logic              w_push;
  logic              w_full;
  logic              w_empty;

  // Stack status and top entry.
  // The top entry is found with a compare-select over the entries, so DEPTH
  // need not be a power of two and no index can fall out of range.
  always_comb begin
    w_full  = (r_sp == SP_W'(DEPTH));
    w_empty = (r_sp == '0);
    w_top   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sp == SP_W'(i + 1)) begin
        w_top = r_stack[i];
      end
    end
  end

  assign w_q_inc = r_q + ADDR_W'(1);

  // Next-state logic. Reset is applied in the register process.
  always_comb begin
    w_q_d   = r_q;
    w_sp_d  = r_sp;
    w_ovf_d = r_ovf;
    w_unf_d = r_unf;
    w_push  = 1'b0;
    if (ret) begin
      // ret wins over call outright, so a coincident call never sets ovf.
      if (w_empty) begin
        w_q_d   = w_q_inc;
        w_unf_d = 1'b1;
      end else begin
        w_q_d  = w_top;
        w_sp_d = r_sp - SP_W'(1);
      end
    end else if (call) begin
      if (w_full) begin
        w_q_d   = w_q_inc;
        w_ovf_d = 1'b1;
      end else begin
        w_push = 1'b1;
        w_sp_d = r_sp + SP_W'(1);
        w_q_d  = D;
      end
    end else if (load) begin
      w_q_d = D;
    end else if (inc) begin
      w_q_d = w_q_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      r_q   <= '0;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_q   <= w_q_d;
      r_sp  <= w_sp_d;
      r_ovf <= w_ovf_d;
      r_unf <= w_unf_d;
    end
  end

  // Stack entries hold no reset value.
  // They are only ever read below sp, and sp resets to zero.
  always_ff @(posedge clk) begin
    if (w_push && !R) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_sp == SP_W'(i)) begin
          r_stack[i] <= w_q_inc;
        end
      end
    end
  end

  assign Q     = r_q;
  assign top   = w_top;
  assign sp    = r_sp;
  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
